// File: rtl/inverse_permutation_decoder.sv
// Inverse pi lane permutation of 5x5 slices with a small output FIFO.
// Frames of SLICES slices are accepted in RUN, drained, then flagged with a one-cycle done.
module inverse_permutation_decoder #(
    parameter int SLICES = 64,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [24:0]               in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [24:0]               out_data,
    output logic [$clog2(SLICES):0]   slice_idx,
    output logic                      busy,
    output logic                      done
);
    localparam int CW = $clog2(SLICES) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] SLICES_C = CW'(SLICES);
    localparam logic [PW:0]   DEPTH_C  = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // D[a][b] = E[b][2(a-b) mod 5]; +10 keeps the modulo operand non-negative
    function automatic logic [24:0] inv_pi(input logic [24:0] e);
        logic [24:0] d;
        logic [4:0]  src;
        logic [4:0]  dst;
        d = 25'd0;
        for (int a = 0; a < 5; a++) begin
            for (int b = 0; b < 5; b++) begin
                dst    = 5'(5 * b + a);
                src    = 5'(5 * ((2 * (a - b) + 10) % 5) + b);
                d[dst] = e[src];
            end
        end
        return d;
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   in_cnt_r, in_cnt_s;
    logic [CW-1:0]   out_cnt_r, out_cnt_s;
    logic [24:0]     mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r, wr_ptr_s;
    logic [PW-1:0]   rd_ptr_r, rd_ptr_s;
    logic [PW:0]     count_r, count_s;
    logic [24:0]     perm_s;
    logic [24:0]     out_data_r, out_data_s;
    logic            out_valid_r, in_ready_r, busy_r, done_r;
    logic            in_ready_s, busy_s, done_s;
    logic            push_s, pop_s;

    assign perm_s = inv_pi(in_data);
    assign push_s = in_valid && in_ready_r;
    assign pop_s  = out_valid_r && out_ready;

    // FIFO pointer/occupancy update and look-ahead of the next head word
    always_comb begin
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        out_data_s = 25'd0;
        if (push_s) begin
            wr_ptr_s = wr_ptr_r + PW'(1'b1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PW'(1'b1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + (PW+1)'(1'b1);
            2'b01:   count_s = count_r - (PW+1)'(1'b1);
            default: count_s = count_r;
        endcase
        // the new head may be the slot being written this very cycle
        if (count_s == {(PW+1){1'b0}}) begin
            out_data_s = 25'd0;
        end else if (push_s && (rd_ptr_s == wr_ptr_r)) begin
            out_data_s = perm_s;
        end else begin
            out_data_s = mem_r[rd_ptr_s];
        end
    end

    // Frame sequencing, slice counters and next values of the status outputs
    always_comb begin
        state_s = state_r;
        if (push_s) begin
            in_cnt_s = in_cnt_r + CW'(1'b1);
        end else begin
            in_cnt_s = in_cnt_r;
        end
        if (pop_s) begin
            out_cnt_s = out_cnt_r + CW'(1'b1);
        end else begin
            out_cnt_s = out_cnt_r;
        end
        case (state_r)
            ST_IDLE: begin
                in_cnt_s  = {CW{1'b0}};
                out_cnt_s = {CW{1'b0}};
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_cnt_s == SLICES_C) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_cnt_s == SLICES_C) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                in_cnt_s  = {CW{1'b0}};
                out_cnt_s = {CW{1'b0}};
                state_s   = ST_IDLE;
            end
            default: begin
                in_cnt_s  = {CW{1'b0}};
                out_cnt_s = {CW{1'b0}};
                state_s   = ST_IDLE;
            end
        endcase
        // in_ready looks only at registered state, so a pop never frees a slot in the same cycle
        in_ready_s = (state_s == ST_RUN) && (in_cnt_s < SLICES_C) && (count_s < DEPTH_C);
        busy_s     = (state_s == ST_RUN) || (state_s == ST_DRAIN);
        done_s     = (state_s == ST_DONE);
    end

    // State, counters, FIFO storage and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_cnt_r    <= {CW{1'b0}};
            out_cnt_r   <= {CW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {(PW+1){1'b0}};
            out_data_r  <= 25'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 25'd0;
            end
        end else begin
            state_r     <= state_s;
            in_cnt_r    <= in_cnt_s;
            out_cnt_r   <= out_cnt_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            out_data_r  <= out_data_s;
            out_valid_r <= (count_s != {(PW+1){1'b0}});
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            if (push_s) begin
                mem_r[wr_ptr_r] <= perm_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign slice_idx = in_cnt_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_inverse_permutation_decoder.sv
// Random-stimulus bench for inverse_permutation_decoder with an encoder-derived reference model.
module tb_inverse_permutation_decoder;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready, in_ready, out_valid, busy, done;
    logic        rand_en, ready_force, rnd_bit;
    logic [24:0] in_data, out_data, exp_word;
    logic [6:0]  slice_idx;
    int          total = 0, bad = 0, cyc = 0;
    int          frame_pops = 0, first_cyc = 0, last_cyc = 0, done_cnt = 0, done_cyc = 0;
    logic        busy_at_last = 1'b0, prev_busy = 1'b0;
    logic [24:0] exp_q [$];

    inverse_permutation_decoder dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .slice_idx(slice_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign out_ready = rand_en ? rnd_bit : ready_force;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Encoder: E[x][y] = D[(x+3y) mod 5][x], lane (x,y) at bit 5y+x
    function automatic logic [24:0] enc_model(input logic [24:0] d);
        logic [24:0] e;
        logic [4:0]  ei, di;
        e = 25'd0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                ei    = 5'(5 * y + x);
                di    = 5'(5 * x + (x + 3 * y) % 5);
                e[ei] = d[di];
            end
        end
        return e;
    endfunction

    // Decoder reference: undo the encoder map lane by lane
    function automatic logic [24:0] dec_ref(input logic [24:0] e);
        logic [24:0] d;
        logic [4:0]  ei, di;
        d = 25'd0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                ei    = 5'(5 * y + x);
                di    = 5'(5 * x + (x + 3 * y) % 5);
                d[di] = e[ei];
            end
        end
        return d;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            frame_pops = 0;
            done_cnt   = 0;
        end else begin
            if (busy && !prev_busy) begin
                frame_pops = 0;
                done_cnt   = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(exp_word);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("out_extra", 32'd1, 32'd0);
                else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                if (frame_pops == 0) first_cyc = cyc;
                last_cyc     = cyc;
                busy_at_last = busy;
                frame_pops++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_busy = busy;
    end

    task automatic push_one(input logic [24:0] e, input logic [24:0] x);
        int n;
        n        = 0;
        in_data  = e;
        exp_word = x;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_done(input bit stream);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 500);
        #1;
        chk("done_seen", 32'(done), 32'd1);
        if (done) begin
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_pops", 32'(frame_pops), 32'd64);
            chk("done_after_last", 32'(done_cyc - last_cyc), 32'd1);
            chk("busy_at_last", 32'(busy_at_last), 32'd1);
            chk("queue_empty", 32'(exp_q.size()), 32'd0);
            if (stream) chk("stream_span", 32'(last_cyc - first_cyc), 32'd63);
            @(negedge clk);
            #1;
            chk("done_pulse", 32'(done), 32'd0);
            chk("done_count", 32'(done_cnt), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_idx", 32'(slice_idx), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] e, d, first_x;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 25'd0; exp_word = 25'd0;
        rand_en = 1'b0; ready_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_idx", 32'(slice_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        #1 rst = 1'b0;

        // traffic while idle is ignored
        in_valid = 1'b1;
        in_data  = 25'($urandom);
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
            chk("idle_slice_idx", 32'(slice_idx), 32'd0);
        end
        in_valid = 1'b0;

        // frame A: single-bit vectors, start during RUN, 65th slice refused
        ready_force = 1'b1;
        start_frame();
        push_one(25'h0000001, 25'h0000001);
        chk("bit0_valid", 32'(out_valid), 32'd1);
        chk("bit0_data", 32'(out_data), 32'h0000001);
        push_one(25'h0000002, 25'h0000040);
        chk("bit1_data", 32'(out_data), 32'h0000040);
        push_one(25'h0000020, 25'h0000008);
        chk("bit5_data", 32'(out_data), 32'h0000008);
        for (int i = 3; i < 64; i++) begin
            e = 25'($urandom);
            if (i == 10) start = 1'b1;
            push_one(e, dec_ref(e));
            start = 1'b0;
            if (i == 10) begin
                chk("start_in_run_idx", 32'(slice_idx), 32'd11);
                chk("start_in_run_busy", 32'(busy), 32'd1);
            end
        end
        ready_force = 1'b0;
        in_data  = 25'($urandom);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("extra_in_ready", 32'(in_ready), 32'd0);
            chk("extra_idx", 32'(slice_idx), 32'd64);
        end
        in_valid = 1'b0;
        ready_force = 1'b1;
        wait_done(1'b0);

        // frame B: encoder/decoder round trip at full throughput
        start_frame();
        for (int i = 0; i < 64; i++) begin
            d = 25'($urandom);
            push_one(enc_model(d), d);
        end
        wait_done(1'b1);

        // frame C: backpressure, then random out_ready
        ready_force = 1'b0;
        start_frame();
        e = 25'($urandom);
        first_x = dec_ref(e);
        push_one(e, first_x);
        e = 25'($urandom);
        push_one(e, dec_ref(e));
        e = 25'($urandom);
        in_data  = e;
        exp_word = dec_ref(e);
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_idx", 32'(slice_idx), 32'd2);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_hold", 32'(out_data), 32'(first_x));
        end
        ready_force = 1'b1;
        push_one(e, dec_ref(e));
        rand_en = 1'b1;
        for (int i = 3; i < 64; i++) begin
            e = 25'($urandom);
            push_one(e, dec_ref(e));
        end
        wait_done(1'b0);
        rand_en = 1'b0;

        // frame D: occupancy held at one, then reset with two buffered
        ready_force = 1'b1;
        start_frame();
        for (int i = 0; i < 29; i++) begin
            e = 25'($urandom);
            push_one(e, dec_ref(e));
            chk("occ1_in_ready", 32'(in_ready), 32'd1);
            chk("occ1_valid", 32'(out_valid), 32'd1);
        end
        ready_force = 1'b0;
        e = 25'($urandom);
        push_one(e, dec_ref(e));
        chk("pre_rst_idx", 32'(slice_idx), 32'd30);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_idx", 32'(slice_idx), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_idx", 32'(slice_idx), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'd0);

        // frame E: clean frame after the mid-frame reset
        ready_force = 1'b1;
        #1;
        start_frame();
        for (int i = 0; i < 64; i++) begin
            e = 25'($urandom);
            push_one(e, dec_ref(e));
        end
        wait_done(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
